// File: rtl/singcyc_dmem_periph.sv
// Data-memory responder for the single-cycle core: word RAM plus a reload timer,
// LEDs, switches and a byte UART transmitter, all decoded from one load/store port.
module singcyc_dmem_periph #(
  parameter int unsigned RAM_WORDS    = 256,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic        iClk,
  input  logic        iRst_n,
  input  logic [31:0] iAddr,
  input  logic        iMemRead,
  input  logic        iMemWrite,
  input  logic [31:0] iWrData,
  output logic [31:0] oRdData,
  input  logic [7:0]  iSwitch,
  output logic [7:0]  oLed,
  output logic        oIrq,
  output logic        oUartTx
);

  localparam int unsigned AW     = $clog2(RAM_WORDS);
  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);

  localparam logic [26:0] PERIPH_PAGE = 27'h200_0000;
  localparam logic [2:0]  OFF_TH   = 3'd0;
  localparam logic [2:0]  OFF_TL   = 3'd1;
  localparam logic [2:0]  OFF_TCON = 3'd2;
  localparam logic [2:0]  OFF_LED  = 3'd3;
  localparam logic [2:0]  OFF_SW   = 3'd4;
  localparam logic [2:0]  OFF_TXD  = 3'd6;
  localparam logic [2:0]  OFF_UCON = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_e;

  logic [31:0]       ram_q [RAM_WORDS];
  logic [31:0]       th_q, th_d, tl_q, tl_d;
  logic [2:0]        tcon_q, tcon_d;
  logic [7:0]        led_q, led_d;
  uart_state_e       state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        data_q, data_d;
  logic              tx_q, tx_d;

  logic          ram_sel, periph_sel, wr_periph, txd_wr, baud_end, tx_busy;
  logic [AW-1:0] ram_idx;
  logic [2:0]    off;
  logic          unused_addr_lsb;

  assign ram_sel         = (iAddr[31:AW+2] == '0);
  assign periph_sel      = (iAddr[31:5] == PERIPH_PAGE);
  assign ram_idx         = iAddr[AW+1:2];
  assign off             = iAddr[4:2];
  assign wr_periph       = iMemWrite && periph_sel;
  assign txd_wr          = wr_periph && (off == OFF_TXD);
  assign baud_end        = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
  assign tx_busy         = (state_q != S_IDLE);
  assign unused_addr_lsb = ^iAddr[1:0];

  // RAM has no reset; contents are undefined until the core writes them.
  always_ff @(posedge iClk) begin
    if (iMemWrite && ram_sel) ram_q[ram_idx] <= iWrData;
  end

  // Combinational read path; shows pre-write state when read and write coincide.
  always_comb begin
    oRdData = '0;
    if (iMemRead) begin
      if (ram_sel) begin
        oRdData = ram_q[ram_idx];
      end else if (periph_sel) begin
        case (off)
          OFF_TH:   oRdData = th_q;
          OFF_TL:   oRdData = tl_q;
          OFF_TCON: oRdData = {29'd0, tcon_q};
          OFF_LED:  oRdData = {24'd0, led_q};
          OFF_SW:   oRdData = {24'd0, iSwitch};
          OFF_UCON: oRdData = {31'd0, tx_busy};
          default:  oRdData = '0;
        endcase
      end
    end
  end

  // Timer count/reload first, then core writes override the same register.
  always_comb begin
    th_d   = th_q;
    tl_d   = tl_q;
    tcon_d = tcon_q;
    led_d  = led_q;
    if (tcon_q[0]) begin
      if (tl_q != 32'hFFFF_FFFF) begin
        tl_d = 32'(tl_q + 32'd1);
      end else begin
        tl_d = th_q;
        if (tcon_q[1]) tcon_d[2] = 1'b1;
      end
    end
    if (wr_periph) begin
      case (off)
        OFF_TH:   th_d   = iWrData;
        OFF_TL:   tl_d   = iWrData;
        OFF_TCON: tcon_d = iWrData[2:0];
        OFF_LED:  led_d  = iWrData[7:0];
        default:  ;
      endcase
    end
  end

  // UART transmit sequencing; the line level is registered from the next state.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (txd_wr) begin
          state_d = S_START;
          data_d  = iWrData[7:0];
          baud_d  = '0;
        end
      end
      S_START: begin
        if (baud_end) begin
          state_d = S_DATA;
          baud_d  = '0;
          bit_d   = '0;
        end else begin
          baud_d = BAUD_W'(baud_q + BAUD_W'(1));
        end
      end
      S_DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = 3'(bit_q + 3'd1);
        end else begin
          baud_d = BAUD_W'(baud_q + BAUD_W'(1));
        end
      end
      S_STOP: begin
        if (baud_end) begin
          state_d = S_IDLE;
          baud_d  = '0;
        end else begin
          baud_d = BAUD_W'(baud_q + BAUD_W'(1));
        end
      end
      default: state_d = S_IDLE;
    endcase
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = data_d[bit_d];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      th_q    <= '0;
      tl_q    <= '0;
      tcon_q  <= '0;
      led_q   <= '0;
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      tx_q    <= 1'b1;
    end else begin
      th_q    <= th_d;
      tl_q    <= tl_d;
      tcon_q  <= tcon_d;
      led_q   <= led_d;
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
    end
  end

  assign oLed    = led_q;
  assign oIrq    = tcon_q[2];
  assign oUartTx = tx_q;

endmodule

// File: tb/tb_singcyc_dmem_periph.sv
// Directed bench for singcyc_dmem_periph: RAM, timer, LED/switch and UART framing.
module tb_singcyc_dmem_periph;

  logic        iClk, iRst_n, iMemRead, iMemWrite, oIrq, oUartTx;
  logic [31:0] iAddr, iWrData, oRdData;
  logic [7:0]  iSwitch, oLed;
  int          checks, errors;

  singcyc_dmem_periph #(.RAM_WORDS(256), .CLKS_PER_BIT(4)) dut (
    .iClk(iClk), .iRst_n(iRst_n), .iAddr(iAddr), .iMemRead(iMemRead),
    .iMemWrite(iMemWrite), .iWrData(iWrData), .oRdData(oRdData),
    .iSwitch(iSwitch), .oLed(oLed), .oIrq(oIrq), .oUartTx(oUartTx)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  // Bus drivers: called at a falling edge, a write spans exactly one rising edge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    iAddr = a; iWrData = d; iMemWrite = 1'b1;
    @(negedge iClk);
    iMemWrite = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    iAddr = a; iMemRead = 1'b1;
    #1;
    d = oRdData;
    iMemRead = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    iRst_n = 1'b0;
    repeat (2) @(negedge iClk);
    iRst_n = 1'b1;
    checks++; if (oUartTx !== 1'b1) begin errors++; $display("FAIL rst_tx got %b exp 1", oUartTx); end
    checks++; if (oIrq !== 1'b0) begin errors++; $display("FAIL rst_irq got %b exp 0", oIrq); end
    checks++; if (oLed !== 8'h00) begin errors++; $display("FAIL rst_led got %h exp 00", oLed); end
    rd(32'h4000_0004, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_tl got %h exp 0", d); end
    rd(32'h4000_0008, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_tcon got %h exp 0", d); end
    rd(32'h4000_001C, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_busy got %h exp 0", d); end
  endtask

  task automatic test_ram;
    logic [31:0] d;
    wr(32'h10, 32'hDEAD_BEEF);
    rd(32'h10, d);
    checks++; if (d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_rd got %h exp deadbeef", d); end
    iAddr = 32'h10; iMemRead = 1'b0; #1;
    checks++; if (oRdData !== 32'h0) begin errors++; $display("FAIL ram_noread got %h exp 0", oRdData); end
    iAddr = 32'h10; iWrData = 32'h1234_5678; iMemRead = 1'b1; iMemWrite = 1'b1; #1;
    checks++; if (oRdData !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_rdw got %h exp deadbeef", oRdData); end
    @(negedge iClk);
    iMemRead = 1'b0; iMemWrite = 1'b0;
    rd(32'h10, d);
    checks++; if (d !== 32'h1234_5678) begin errors++; $display("FAIL ram_after got %h exp 12345678", d); end
    wr(32'h3FC, 32'hA5A5_0001);
    rd(32'h3FC, d);
    checks++; if (d !== 32'hA5A5_0001) begin errors++; $display("FAIL ram_top got %h exp a5a50001", d); end
    rd(32'h10, d);
    checks++; if (d !== 32'h1234_5678) begin errors++; $display("FAIL ram_keep got %h exp 12345678", d); end
  endtask

  task automatic test_timer_irq;
    logic [31:0] d;
    wr(32'h4000_0000, 32'hFFFF_FFF0);
    wr(32'h4000_0004, 32'hFFFF_FFFE);
    wr(32'h4000_0008, 32'h3);
    repeat (2) @(negedge iClk);
    rd(32'h4000_0004, d);
    checks++; if (d !== 32'hFFFF_FFF0) begin errors++; $display("FAIL tmr_reload got %h exp fffffff0", d); end
    checks++; if (oIrq !== 1'b1) begin errors++; $display("FAIL tmr_irq got %b exp 1", oIrq); end
    @(negedge iClk);
    rd(32'h4000_0008, d);
    checks++; if (d !== 32'h7) begin errors++; $display("FAIL tmr_sticky got %h exp 7", d); end
    wr(32'h4000_0008, 32'h3);
    checks++; if (oIrq !== 1'b0) begin errors++; $display("FAIL tmr_clr got %b exp 0", oIrq); end
    rd(32'h4000_0008, d);
    checks++; if (d !== 32'h3) begin errors++; $display("FAIL tmr_tcon got %h exp 3", d); end
  endtask

  task automatic test_timer_write_wins;
    logic [31:0] d;
    wr(32'h4000_0008, 32'h0);
    wr(32'h4000_0000, 32'h0000_0100);
    wr(32'h4000_0004, 32'hFFFF_FFFE);
    wr(32'h4000_0008, 32'h1);
    @(negedge iClk);
    rd(32'h4000_0004, d);
    checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL tw_pre got %h exp ffffffff", d); end
    wr(32'h4000_0004, 32'h5);
    rd(32'h4000_0004, d);
    checks++; if (d !== 32'h5) begin errors++; $display("FAIL tw_win got %h exp 5", d); end
    @(negedge iClk);
    rd(32'h4000_0004, d);
    checks++; if (d !== 32'h6) begin errors++; $display("FAIL tw_next got %h exp 6", d); end
    checks++; if (oIrq !== 1'b0) begin errors++; $display("FAIL tw_irq got %b exp 0", oIrq); end
    wr(32'h4000_0008, 32'h0);
  endtask

  task automatic test_uart_frame;
    logic [31:0] d;
    logic [9:0]  frame;
    frame = {1'b1, 8'hA5, 1'b0};
    wr(32'h4000_0018, 32'h0000_00A5);
    for (int k = 0; k < 40; k++) begin
      checks++; if (oUartTx !== frame[k/4]) begin errors++; $display("FAIL uart_bit k=%0d got %b exp %b", k, oUartTx, frame[k/4]); end
      rd(32'h4000_001C, d);
      checks++; if (d !== 32'h1) begin errors++; $display("FAIL uart_busy k=%0d got %h exp 1", k, d); end
      @(negedge iClk);
    end
    rd(32'h4000_001C, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL uart_done got %h exp 0", d); end
    checks++; if (oUartTx !== 1'b1) begin errors++; $display("FAIL uart_idle got %b exp 1", oUartTx); end
  endtask

  task automatic test_uart_busy_drop_and_reset;
    logic [31:0] d;
    logic [9:0]  frame;
    frame = {1'b1, 8'hA5, 1'b0};
    wr(32'h4000_0018, 32'h0000_00A5);
    for (int k = 0; k < 40; k++) begin
      checks++; if (oUartTx !== frame[k/4]) begin errors++; $display("FAIL drop_bit k=%0d got %b exp %b", k, oUartTx, frame[k/4]); end
      iAddr = 32'h4000_0018; iWrData = 32'h0000_003C; iMemWrite = (k == 6);
      @(negedge iClk);
      iMemWrite = 1'b0;
    end
    rd(32'h4000_001C, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL drop_done got %h exp 0", d); end
    wr(32'h4000_0018, 32'h0000_00A5);
    repeat (9) @(negedge iClk);
    checks++; if (oUartTx !== 1'b0) begin errors++; $display("FAIL mid_pre got %b exp 0", oUartTx); end
    iRst_n = 1'b0;
    @(negedge iClk);
    iRst_n = 1'b1;
    checks++; if (oUartTx !== 1'b1) begin errors++; $display("FAIL mid_rst_tx got %b exp 1", oUartTx); end
    rd(32'h4000_001C, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL mid_rst_busy got %h exp 0", d); end
  endtask

  task automatic test_gpio_unmapped;
    logic [31:0] d;
    iSwitch = 8'h5A;
    rd(32'h4000_0010, d);
    checks++; if (d !== 32'h5A) begin errors++; $display("FAIL sw_rd got %h exp 5a", d); end
    wr(32'h4000_000C, 32'h0000_01FF);
    checks++; if (oLed !== 8'hFF) begin errors++; $display("FAIL led_out got %h exp ff", oLed); end
    rd(32'h4000_000C, d);
    checks++; if (d !== 32'hFF) begin errors++; $display("FAIL led_rd got %h exp ff", d); end
    rd(32'h5000_0000, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL unmap_rd got %h exp 0", d); end
    wr(32'h4000_0010, 32'hFFFF_FFFF);
    rd(32'h4000_0010, d);
    checks++; if (d !== 32'h5A) begin errors++; $display("FAIL sw_ro got %h exp 5a", d); end
    checks++; if (oLed !== 8'hFF) begin errors++; $display("FAIL led_keep got %h exp ff", oLed); end
    rd(32'h4000_0018, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL txd_wo got %h exp 0", d); end
    rd(32'h0000_0400, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL ram_oob got %h exp 0", d); end
  endtask

  initial begin
    checks = 0; errors = 0;
    iRst_n = 1'b0; iAddr = '0; iWrData = '0; iMemRead = 1'b0; iMemWrite = 1'b0; iSwitch = '0;
    @(negedge iClk);
    test_reset();
    test_ram();
    test_timer_irq();
    test_timer_write_wins();
    test_uart_frame();
    test_uart_busy_drop_and_reset();
    test_gpio_unmapped();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
